// File: rtl/nios2_oci_dct_pkg.sv
// Shared definitions for the OCI debug-capture-trace (DCT) sequencer.
//   - state_e : sequencer states (FILL collects items, HOLD presents the
//               buffer to the sink, DONE is the terminal end-of-test state)
//   - ITEM_W, SLOTS, BUF_W, CNT_W : trace item / buffer geometry
//   - item_t  : one trace item
package nios2_oci_dct_pkg;

  localparam int ITEM_W = 10;
  localparam int SLOTS  = 3;
  localparam int BUF_W  = ITEM_W * SLOTS;
  localparam int CNT_W  = 4;

  typedef logic [ITEM_W-1:0] item_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nios2_oci_dct_sequencer_if.sv
// Trace-source and trace-sink handshake bundle of the DCT sequencer.
//   src0_* : instruction-trace source (valid/item in, ready out)
//   src1_* : data-trace source (valid/item in, ready out)
//   dct_*  : buffer sink (valid/buffer/count out, ready in)
// Modports:
//   master : the sequencer side
//   slave  : the environment (trace sources and sink)
interface nios2_oci_dct_sequencer_if;
  import nios2_oci_dct_pkg::*;

  logic             src0_valid;
  item_t            src0_item;
  logic             src0_ready;
  logic             src1_valid;
  item_t            src1_item;
  logic             src1_ready;
  logic             dct_valid;
  logic             dct_ready;
  logic [BUF_W-1:0] dct_buffer;
  logic [CNT_W-1:0] dct_count;

  modport master (
    input  src0_valid, src0_item, src1_valid, src1_item, dct_ready,
    output src0_ready, src1_ready, dct_valid, dct_buffer, dct_count
  );

  modport slave (
    output src0_valid, src0_item, src1_valid, src1_item, dct_ready,
    input  src0_ready, src1_ready, dct_valid, dct_buffer, dct_count
  );

endinterface

// File: rtl/nios2_oci_dct_rr_arb.sv
// Two-way round-robin arbiter.
//   clk, reset_n : clock and asynchronous active-low reset
//   valid[1:0]   : request from source 0 / source 1
//   enable       : arbitration allowed this cycle
//   grant[1:0]   : one-hot combinational grant (0 when disabled)
// On a tie the source that did not win the most recent grant wins. The
// priority flag only moves when a grant is actually issued.
module nios2_oci_dct_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  // prio1_q set: source 1 wins a tie (source 0 won last)
  logic prio1_q, prio1_d;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio1_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
    prio1_d = prio1_q;
    if (grant[0]) begin
      prio1_d = 1'b1;
    end else if (grant[1]) begin
      prio1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio1_q <= 1'b0;
    end else begin
      prio1_q <= prio1_d;
    end
  end

endmodule

// File: rtl/nios2_oci_dct_sequencer.sv
// OCI DCT buffer sequencer: packs instruction/data trace items into a
// three-slot buffer, hands full or flushed buffers to the sink over a
// valid/ready handshake and sequences the end-of-test drain.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   bus (master)   : trace sources and buffer sink handshake
//   flush_req      : pulse, flush a partially filled buffer
//   test_ending    : level, start the end-of-test drain
//   test_has_ended : sticky, set once the final flush has completed
//   stall_count    : cycles with a pending source and no grant
// Optional feature: define NIOS2_OCI_DCT_STALL_CNT_EN to build the
// saturating stall counter; otherwise stall_count is tied to 0.
module nios2_oci_dct_sequencer
  import nios2_oci_dct_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TMO_W   = 7
) (
  input  logic                       clk,
  input  logic                       reset_n,
  nios2_oci_dct_sequencer_if.master  bus,
  input  logic                       flush_req,
  input  logic                       test_ending,
  output logic                       test_has_ended,
  output logic [15:0]                stall_count
);

  localparam logic [CNT_W-1:0] SLOTS_C   = CNT_W'(SLOTS);
  localparam logic [TMO_W-1:0] TIMEOUT_C = TMO_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             end_pending_q, end_pending_d;
  logic             dct_valid_q, dct_valid_d;
  logic             ended_q, ended_d;

  logic [1:0] grant;
  logic       arb_en;
  logic       accept;
  item_t      acc_item;

  // Gated by reset_n so the ready outputs are 0 while reset is held.
  assign arb_en = reset_n && (state_q == FILL) && (cnt_q < SLOTS_C);

  nios2_oci_dct_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   ({bus.src1_valid, bus.src0_valid}),
    .enable  (arb_en),
    .grant   (grant)
  );

  assign accept   = |grant;
  assign acc_item = grant[1] ? bus.src1_item : bus.src0_item;

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    end_pending_d = end_pending_q;
    dct_valid_d   = dct_valid_q;
    ended_d       = ended_q | (state_q == DONE);

    case (state_q)
      FILL: begin
        if (accept) begin
          for (int k = 0; k < SLOTS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              buf_d[k*ITEM_W +: ITEM_W] = acc_item;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          tmo_d = '0;
        end else if (cnt_q != '0) begin
          tmo_d = tmo_q + TMO_W'(1);
        end else begin
          tmo_d = '0;
        end

        // Decisions use the post-accept count so an item accepted this
        // cycle rides along with a flush or end-of-test drain.
        if (test_ending) begin
          if (cnt_d != '0) begin
            state_d       = HOLD;
            end_pending_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else if ((cnt_d == SLOTS_C) ||
                     ((cnt_d != '0) && (flush_req || (tmo_d == TIMEOUT_C)))) begin
          state_d = HOLD;
        end

        dct_valid_d = (state_d == HOLD);
        if (state_d == HOLD) begin
          tmo_d = '0;
        end
      end

      HOLD: begin
        if (test_ending) begin
          end_pending_d = 1'b1;
        end
        if (bus.dct_ready) begin
          buf_d       = '0;
          cnt_d       = '0;
          dct_valid_d = 1'b0;
          state_d     = (end_pending_q || test_ending) ? DONE : FILL;
        end
      end

      default: begin
        // DONE is terminal; only reset leaves it.
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FILL;
      buf_q         <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      end_pending_q <= 1'b0;
      dct_valid_q   <= 1'b0;
      ended_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      end_pending_q <= end_pending_d;
      dct_valid_q   <= dct_valid_d;
      ended_q       <= ended_d;
    end
  end

  assign bus.src0_ready = grant[0];
  assign bus.src1_ready = grant[1];
  assign bus.dct_valid  = dct_valid_q;
  assign bus.dct_buffer = buf_q;
  assign bus.dct_count  = cnt_q;
  assign test_has_ended = ended_q;

`ifdef NIOS2_OCI_DCT_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((bus.src0_valid || bus.src1_valid) && !accept && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_nios2_oci_dct_sequencer.sv
// Self-checking bench for nios2_oci_dct_sequencer: directed scenarios plus
// randomized traffic, compared every cycle against an item-queue model.
module tb_nios2_oci_dct_sequencer;

  localparam int TB_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_req;
  logic        test_ending;
  logic        test_has_ended;
  logic [15:0] stall_count;

  nios2_oci_dct_sequencer_if bus ();

  nios2_oci_dct_sequencer #(.TIMEOUT(TB_TIMEOUT), .TMO_W(7)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .flush_req      (flush_req),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 collecting items, 1 presenting buffer, 2 finished
  int         m_phase  = 0;
  logic [9:0] m_items[$];
  bit         m_last1  = 1'b1;  // src1 won last, so src0 wins the first tie
  int         m_idle   = 0;
  bit         m_endp   = 1'b0;
  bit         m_ended  = 1'b0;
  int         m_stall  = 0;

  function automatic logic [29:0] m_packed();
    logic [29:0] r = '0;
    foreach (m_items[k]) r = r | (30'(m_items[k]) << (10 * k));
    return r;
  endfunction

  function automatic logic [1:0] m_grant();
    if (m_phase != 0 || m_items.size() >= 3) return 2'b00;
    if (bus.src0_valid && bus.src1_valid) return m_last1 ? 2'b01 : 2'b10;
    if (bus.src0_valid) return 2'b01;
    if (bus.src1_valid) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_items.delete();
    m_last1 = 1'b1;
    m_idle  = 0;
    m_endp  = 1'b0;
    m_ended = 1'b0;
    m_stall = 0;
  endtask

  task automatic model_step();
    logic [1:0] g;
    int old_phase;
    g = m_grant();
    old_phase = m_phase;
`ifdef NIOS2_OCI_DCT_STALL_CNT_EN
    if ((bus.src0_valid || bus.src1_valid) && g == 2'b00 && m_stall < 65535) m_stall++;
`endif
    if (m_phase == 0) begin
      if (g != 2'b00) begin
        m_items.push_back(g[1] ? bus.src1_item : bus.src0_item);
        m_last1 = g[1];
        m_idle  = 0;
      end else if (m_items.size() > 0) begin
        m_idle++;
      end
      if (test_ending) begin
        if (m_items.size() > 0) begin
          m_phase = 1;
          m_endp  = 1'b1;
        end else begin
          m_phase = 2;
        end
      end else if (m_items.size() == 3 ||
                   (m_items.size() > 0 && (flush_req || m_idle == TB_TIMEOUT))) begin
        m_phase = 1;
      end
      if (m_phase == 1) m_idle = 0;
    end else if (m_phase == 1) begin
      if (test_ending) m_endp = 1'b1;
      if (bus.dct_ready) begin
        m_items.delete();
        m_phase = m_endp ? 2 : 0;
      end
    end
    if (old_phase == 2) m_ended = 1'b1;
  endtask

  // Per-cycle compare: inputs change on the falling edge, outputs are
  // checked 2 ns later and the model then advances by one clock.
  always begin
    logic [1:0] g;
    @(negedge clk);
    #2;
    if (!reset_n) begin
      model_reset();
      chk("rst_src0_ready", {31'b0, bus.src0_ready}, 32'd0);
      chk("rst_src1_ready", {31'b0, bus.src1_ready}, 32'd0);
      chk("rst_dct_valid",  {31'b0, bus.dct_valid},  32'd0);
      chk("rst_dct_buffer", {2'b0, bus.dct_buffer},  32'd0);
      chk("rst_dct_count",  {28'b0, bus.dct_count},  32'd0);
      chk("rst_ended",      {31'b0, test_has_ended}, 32'd0);
      chk("rst_stall",      {16'b0, stall_count},    32'd0);
    end else begin
      g = m_grant();
      chk("src0_ready", {31'b0, bus.src0_ready}, {31'b0, g[0]});
      chk("src1_ready", {31'b0, bus.src1_ready}, {31'b0, g[1]});
      chk("dct_valid",  {31'b0, bus.dct_valid},  (m_phase == 1) ? 32'd1 : 32'd0);
      chk("dct_buffer", {2'b0, bus.dct_buffer},  {2'b0, m_packed()});
      chk("dct_count",  {28'b0, bus.dct_count},  32'(m_items.size()));
      chk("test_has_ended", {31'b0, test_has_ended}, {31'b0, m_ended});
      chk("stall_count", {16'b0, stall_count}, 32'(m_stall));
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v0, input logic [9:0] i0, input bit v1, input logic [9:0] i1,
                     input bit fl, input bit te, input bit rdy);
    @(negedge clk);
    bus.src0_valid = v0;
    bus.src0_item  = i0;
    bus.src1_valid = v1;
    bus.src1_item  = i1;
    flush_req      = fl;
    test_ending    = te;
    bus.dct_ready  = rdy;
  endtask

  task automatic do_reset();
    cyc(0, 10'h0, 0, 10'h0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;
    int pct;
    reset_n        = 1'b0;
    bus.src0_valid = 1'b0;
    bus.src0_item  = '0;
    bus.src1_valid = 1'b0;
    bus.src1_item  = '0;
    bus.dct_ready  = 1'b0;
    flush_req      = 1'b0;
    test_ending    = 1'b0;
    do_reset();

    // Fill: three back-to-back src0 items
    cyc(1, 10'h001, 0, 10'h0, 0, 0, 1);
    #1 chk("fill_first_ready", {31'b0, bus.src0_ready}, 32'd1);
    cyc(1, 10'h002, 0, 10'h0, 0, 0, 1);
    cyc(1, 10'h003, 0, 10'h0, 0, 0, 1);
    cyc(0, 10'h0, 0, 10'h0, 0, 0, 1);
    #1;
    chk("fill_valid", {31'b0, bus.dct_valid}, 32'd1);
    chk("fill_buffer", {2'b0, bus.dct_buffer}, 32'h00300801);
    chk("fill_count", {28'b0, bus.dct_count}, 32'd3);
    chk("model_fill_buffer", {2'b0, m_packed()}, 32'h00300801);

    // Arbitration: both sources continuously valid
    do_reset();
    cyc(1, 10'h0AA, 1, 10'h155, 0, 0, 1);
    #1 chk("arb_grant1_src0", {30'b0, bus.src1_ready, bus.src0_ready}, 32'd1);
    cyc(1, 10'h0BB, 1, 10'h155, 0, 0, 1);
    #1 chk("arb_grant2_src1", {30'b0, bus.src1_ready, bus.src0_ready}, 32'd2);
    cyc(1, 10'h0BB, 1, 10'h166, 0, 0, 1);
    #1 chk("arb_grant3_src0", {30'b0, bus.src1_ready, bus.src0_ready}, 32'd1);
    cyc(0, 10'h0, 0, 10'h0, 0, 0, 1);
    #1;
    chk("arb_buffer", {2'b0, bus.dct_buffer}, 32'h0BB554AA);
    chk("model_arb_buffer", {2'b0, m_packed()}, 32'h0BB554AA);

    // Partial flush
    do_reset();
    cyc(1, 10'h3FF, 0, 10'h0, 0, 0, 0);
    cyc(0, 10'h0, 0, 10'h0, 0, 0, 0);
    cyc(0, 10'h0, 0, 10'h0, 1, 0, 0);
    cyc(0, 10'h0, 0, 10'h0, 0, 0, 1);
    #1;
    chk("flush_valid", {31'b0, bus.dct_valid}, 32'd1);
    chk("flush_buffer", {2'b0, bus.dct_buffer}, 32'h000003FF);
    chk("flush_count", {28'b0, bus.dct_count}, 32'd1);
    cyc(0, 10'h0, 0, 10'h0, 0, 0, 0);

    // Timeout, then back-pressure
    cyc(1, 10'h123, 0, 10'h0, 0, 0, 0);
    seen = 1'b0;
    n = 0;
    for (int k = 0; k < TB_TIMEOUT + 5 && !seen; k++) begin
      cyc(0, 10'h0, 0, 10'h0, 0, 0, 0);
      #1;
      if (bus.dct_valid) seen = 1'b1;
      else n++;
    end
    chk("timeout_seen", {31'b0, seen}, 32'd1);
    chk("timeout_idle_cycles", 32'(n), 32'(TB_TIMEOUT));
    for (int k = 0; k < 5; k++) begin
      cyc(1, 10'h055, 1, 10'h0AA, 0, 0, 0);
      #1;
      chk("bp_buffer", {2'b0, bus.dct_buffer}, 32'h00000123);
      chk("bp_readies", {30'b0, bus.src1_ready, bus.src0_ready}, 32'd0);
      chk("bp_valid", {31'b0, bus.dct_valid}, 32'd1);
    end
    cyc(0, 10'h0, 0, 10'h0, 0, 0, 1);

    // End of test with two buffered items
    do_reset();
    cyc(1, 10'h011, 0, 10'h0, 0, 0, 0);
    cyc(1, 10'h022, 0, 10'h0, 0, 0, 0);
    cyc(0, 10'h0, 0, 10'h0, 0, 1, 0);
    cyc(0, 10'h0, 0, 10'h0, 0, 1, 0);
    #1;
    chk("end_valid", {31'b0, bus.dct_valid}, 32'd1);
    chk("end_count", {28'b0, bus.dct_count}, 32'd2);
    cyc(0, 10'h0, 0, 10'h0, 0, 1, 1);
    for (int k = 0; k < 6; k++) begin
      cyc(1, 10'h1C3, 1, 10'h2C4, 0, 1, 1);
      #1 chk("end_no_grant", {30'b0, bus.src1_ready, bus.src0_ready}, 32'd0);
    end
    chk("end_has_ended", {31'b0, test_has_ended}, 32'd1);

    // End of test with an empty buffer
    do_reset();
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc(0, 10'h0, 0, 10'h0, 0, 1, 1);
      #1 if (bus.dct_valid) seen = 1'b1;
    end
    chk("empty_end_no_valid", {31'b0, seen}, 32'd0);
    chk("empty_end_has_ended", {31'b0, test_has_ended}, 32'd1);

    // Stall counting in HOLD, then asynchronous reset mid-HOLD
    do_reset();
    cyc(1, 10'h001, 0, 10'h0, 0, 0, 0);
    cyc(1, 10'h002, 0, 10'h0, 0, 0, 0);
    cyc(1, 10'h003, 0, 10'h0, 0, 0, 0);
    for (int k = 0; k < 10; k++) cyc(1, 10'h2AA, 0, 10'h0, 0, 0, 0);
    cyc(0, 10'h0, 0, 10'h0, 0, 0, 0);
    #1;
    chk("hold_before_reset", {31'b0, bus.dct_valid}, 32'd1);
`ifdef NIOS2_OCI_DCT_STALL_CNT_EN
    chk("stall_count_10", {16'b0, stall_count}, 32'd10);
`else
    chk("stall_count_off", {16'b0, stall_count}, 32'd0);
`endif
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, bus.dct_valid}, 32'd0);
    chk("async_rst_buffer", {2'b0, bus.dct_buffer}, 32'd0);
    chk("async_rst_count", {28'b0, bus.dct_count}, 32'd0);
    chk("async_rst_stall", {16'b0, stall_count}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic in segments of differing source activity
    for (int s = 0; s < 20; s++) begin
      case ($urandom_range(0, 3))
        0: pct = 0;
        1: pct = 10;
        2: pct = 50;
        default: pct = 90;
      endcase
      for (int k = 0; k < 100; k++) begin
        cyc($urandom_range(0, 99) < pct, 10'($urandom),
            $urandom_range(0, 99) < pct, 10'($urandom),
            $urandom_range(0, 99) < 3, 1'b0,
            $urandom_range(0, 99) < 70);
      end
    end
    cyc(0, 10'h0, 0, 10'h0, 0, 0, 0);
    @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
